// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit: ALU control codes,
// operation codes, FSM states and small op-decoding helpers.
package muldiv_seq_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIVU) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling for muldiv_seq: operand magnitudes on entry and the final
// conditional negation of the 64-bit product or the quotient/remainder pair.
module muldiv_signfix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_signed_i,
  input  logic             is_div_i,
  input  logic             neg_res_i,
  input  logic             neg_rem_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic [WIDTH-1:0] res_hi_i,
  input  logic [WIDTH-1:0] res_lo_i,
  output logic [WIDTH-1:0] abs_rs_o,
  output logic [WIDTH-1:0] abs_rt_o,
  output logic [WIDTH-1:0] fix_hi_o,
  output logic [WIDTH-1:0] fix_lo_o
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    abs_rs_o = (is_signed_i && rs_i[WIDTH-1]) ? (~rs_i + 1'b1) : rs_i;
    abs_rt_o = (is_signed_i && rt_i[WIDTH-1]) ? (~rt_i + 1'b1) : rt_i;
  end

  always_comb begin
    prod     = {res_hi_i, res_lo_i};
    prod_neg = ~prod + 1'b1;
    fix_hi_o = res_hi_i;
    fix_lo_o = res_lo_i;
    if (is_div_i) begin
      // Quotient follows the operand signs, remainder follows the dividend.
      if (neg_rem_i) fix_hi_o = ~res_hi_i + 1'b1;
      if (neg_res_i) fix_lo_o = ~res_lo_i + 1'b1;
    end else if (neg_res_i) begin
      {fix_hi_o, fix_lo_o} = prod_neg;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit that borrows the shared ALU for one
// add/sub per iteration (shift-add multiply, restoring divide) into HI/LO.
module muldiv_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          ZDIV_FAST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_result
);
  import muldiv_seq_pkg::*;

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  op_e              op_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rs_q, rt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             neg_res_q, neg_rem_q;
  logic             busy_q, done_q, own_q;

  logic             is_div, is_signed, zdiv;
  logic [WIDTH-1:0] abs_rs, abs_rt, fix_hi, fix_lo;
  logic [WIDTH-1:0] acc_hi_d, acc_lo_d;
  logic [WIDTH:0]   rem_sh, mul_sum;
  logic             carry, take;

  assign is_div    = op_is_div(op_q);
  assign is_signed = op_is_signed(op_q);
  assign zdiv      = ZDIV_FAST && is_div && (rt_q == '0);

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign alu_own = own_q;

  muldiv_signfix #(
    .WIDTH(WIDTH)
  ) u_signfix (
    .is_signed_i (is_signed),
    .is_div_i    (is_div),
    .neg_res_i   (neg_res_q),
    .neg_rem_i   (neg_rem_q),
    .rs_i        (rs_q),
    .rt_i        (rt_q),
    .res_hi_i    (acc_hi_q),
    .res_lo_i    (acc_lo_q),
    .abs_rs_o    (abs_rs),
    .abs_rt_o    (abs_rt),
    .fix_hi_o    (fix_hi),
    .fix_lo_o    (fix_lo)
  );

  // ALU drive is only non-zero while the unit owns the ALU.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = ALU_ADD;
    if (state_q == S_ITER) begin
      alu_a   = is_div ? rem_sh[WIDTH-1:0] : acc_hi_q;
      alu_b   = opnd_q;
      alu_ctr = is_div ? ALU_SUB : ALU_ADD;
    end
  end

  // acc_hi/acc_lo hold {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    rem_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    carry   = alu_result < alu_a;
    take    = rem_sh[WIDTH] | (rem_sh >= {1'b0, opnd_q});
    mul_sum = acc_lo_q[0] ? {carry, alu_result} : {1'b0, acc_hi_q};
    if (is_div) begin
      acc_hi_d = take ? alu_result : rem_sh[WIDTH-1:0];
      acc_lo_d = {acc_lo_q[WIDTH-2:0], take};
    end else begin
      acc_hi_d = mul_sum[WIDTH:1];
      acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULTU;
      cnt_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      own_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op_e'(op);
            rs_q    <= rs;
            rt_q    <= rt;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (zdiv) begin
            hi_q    <= rs_q;
            lo_q    <= '1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            neg_res_q <= is_signed & (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
            neg_rem_q <= is_signed & rs_q[WIDTH-1];
            acc_hi_q  <= '0;
            acc_lo_q  <= is_div ? abs_rs : abs_rt;
            opnd_q    <= is_div ? abs_rt : abs_rs;
            cnt_q     <= '0;
            own_q     <= 1'b1;
            state_q   <= S_ITER;
          end
        end
        S_ITER: begin
          if (flush) begin
            busy_q  <= 1'b0;
            own_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              own_q   <= 1'b0;
              state_q <= S_FIX;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            hi_q    <= fix_hi;
            lo_q    <= fix_lo;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          own_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases, start/flush/reset
// interactions and randomized operations against an arithmetic reference model.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [1:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done, alu_own;
  logic [31:0] hi, lo, alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctr;

  logic [31:0] core_a = 32'h1234_5678, core_b = 32'h0F0F_0F0F;
  logic [2:0]  core_ctr = ALU_OR;
  logic [31:0] mux_a, mux_b;
  logic [2:0]  mux_ctr;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] prev_hi, prev_lo;

  typedef struct packed {
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;
    logic [7:0]  elat;
  } vec_t;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32), .ZDIV_FAST(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_result(alu_result)
  );

  // Shared ALU behind the ownership mux; the core side keeps busy with noise.
  assign mux_a   = alu_own ? alu_a   : core_a;
  assign mux_b   = alu_own ? alu_b   : core_b;
  assign mux_ctr = alu_own ? alu_ctr : core_ctr;

  always_comb begin
    case (mux_ctr)
      ALU_ADD:  alu_result = mux_a + mux_b;
      ALU_SUB:  alu_result = mux_a - mux_b;
      ALU_OR:   alu_result = mux_a | mux_b;
      ALU_SLT:  alu_result = {31'b0, $signed(mux_a) < $signed(mux_b)};
      ALU_SLTU: alu_result = {31'b0, mux_a < mux_b};
      default:  alu_result = '0;
    endcase
  end

  always @(posedge clk) begin
    core_a   <= $urandom;
    core_b   <= $urandom;
    core_ctr <= ALU_OR;
  end

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: return ua * ub;
      2'b10: return sa * sb;
      2'b01: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Launches one op from IDLE and waits (bounded) for done; returns one cycle later in IDLE.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, b, input bit fl,
                        output logic [31:0] h, l, output int lat, output bit own_seen);
    op = o; rs = a; rt = b; start = 1'b1; flush = fl;
    lat = 0; own_seen = 1'b0;
    do begin
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      lat++;
      if (alu_own) own_seen = 1'b1;
    end while (!done && lat < 100);
    h = hi; l = lo;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs = '0; rt = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, done, alu_own} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags: got %b expected 000", {busy, done, alu_own});
    end
    tests_run++;
    if ({hi, lo} !== 64'h0) begin
      tests_failed++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    end
    tests_run++;
    if ({alu_a, alu_b, alu_ctr} !== 67'h0) begin
      tests_failed++; $display("FAIL reset_alu: got a=%h b=%h ctr=%b expected zeros", alu_a, alu_b, alu_ctr);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    prev_hi = '0; prev_lo = '0;
  endtask

  task automatic test_directed();
    vec_t dv[$];
    logic [31:0] h, l;
    int lat;
    bit own;
    dv.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 8'd35});
    dv.push_back('{2'b10, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 8'd35});
    dv.push_back('{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 8'd35});
    dv.push_back('{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 8'd35});
    dv.push_back('{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 8'd35});
    dv.push_back('{2'b01, 32'd100,       32'd7,        32'd2,         32'd14,        8'd35});
    dv.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 8'd35});
    dv.push_back('{2'b01, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 8'd2});
    foreach (dv[i]) begin
      run_op(dv[i].o, dv[i].a, dv[i].b, 1'b0, h, l, lat, own);
      tests_run++;
      if ({h, l} !== {dv[i].eh, dv[i].el}) begin
        tests_failed++;
        $display("FAIL directed_%0d_result: got hi=%h lo=%h expected hi=%h lo=%h", i, h, l, dv[i].eh, dv[i].el);
      end
      tests_run++;
      if (lat !== int'(dv[i].elat)) begin
        tests_failed++; $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, dv[i].elat);
      end
      tests_run++;
      if (own !== (dv[i].elat != 8'd2)) begin
        tests_failed++; $display("FAIL directed_%0d_alu_own: got %b expected %b", i, own, dv[i].elat != 8'd2);
      end
      prev_hi = dv[i].eh; prev_lo = dv[i].el;
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] a, b;
    logic [63:0] exp;
    int lat;
    bit seen;
    a = $urandom; b = $urandom;
    exp = ref_model(2'b10, a, b);
    op = 2'b10; rs = a; rt = b; start = 1'b1; lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      start = (lat == 10);
      if (lat == 10) begin op = 2'b01; rs = $urandom; rt = $urandom | 32'h1; end
    end while (!done && lat < 100);
    start = 1'b0;
    tests_run++;
    if (lat !== 35) begin
      tests_failed++; $display("FAIL start_ignored_latency: got %0d expected 35", lat);
    end
    tests_run++;
    if ({hi, lo} !== exp) begin
      tests_failed++; $display("FAIL start_ignored_result: got %h expected %h", {hi, lo}, exp);
    end
    prev_hi = exp[63:32]; prev_lo = exp[31:0];
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++; $display("FAIL start_ignored_no_queue: got activity=%b expected 0", seen);
    end
  endtask

  task automatic test_flush();
    logic [31:0] a, b, h, l;
    logic [63:0] exp;
    int lat;
    bit own, seen;
    // flush together with start in IDLE: start wins.
    a = $urandom; b = $urandom_range(1, 1000);
    exp = ref_model(2'b01, a, b);
    run_op(2'b01, a, b, 1'b1, h, l, lat, own);
    tests_run++;
    if ({h, l} !== exp || lat !== 35) begin
      tests_failed++; $display("FAIL flush_with_start: got %h lat=%0d expected %h lat=35", {h, l}, lat, exp);
    end
    prev_hi = exp[63:32]; prev_lo = exp[31:0];
    // flush at iteration 10 of a DIV.
    op = 2'b11; rs = $urandom; rt = $urandom; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests_run++;
    if ({busy, alu_own, done} !== 3'b000) begin
      tests_failed++; $display("FAIL flush_idle: got busy/own/done=%b expected 000", {busy, alu_own, done});
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++; $display("FAIL flush_no_done: got done seen=%b expected 0", seen);
    end
    tests_run++;
    if ({hi, lo} !== {prev_hi, prev_lo}) begin
      tests_failed++; $display("FAIL flush_hilo_kept: got %h expected %h", {hi, lo}, {prev_hi, prev_lo});
    end
    a = $urandom; b = $urandom;
    exp = ref_model(2'b00, a, b);
    run_op(2'b00, a, b, 1'b0, h, l, lat, own);
    tests_run++;
    if ({h, l} !== exp || lat !== 35) begin
      tests_failed++; $display("FAIL flush_next_op: got %h lat=%0d expected %h lat=35", {h, l}, lat, exp);
    end
    prev_hi = exp[63:32]; prev_lo = exp[31:0];
  endtask

  task automatic test_reset_midop();
    logic [31:0] a, b, h, l;
    logic [63:0] exp;
    int lat;
    bit own;
    op = 2'b10; rs = $urandom; rt = $urandom; start = 1'b1;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({busy, alu_own, done} !== 3'b000 || {hi, lo} !== 64'h0 || alu_a !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_midop: got busy/own/done=%b hilo=%h alu_a=%h expected all zero",
               {busy, alu_own, done}, {hi, lo}, alu_a);
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;
    a = $urandom; b = $urandom_range(1, 50);
    exp = ref_model(2'b11, a, b);
    run_op(2'b11, a, b, 1'b0, h, l, lat, own);
    tests_run++;
    if ({h, l} !== exp) begin
      tests_failed++; $display("FAIL reset_recover: got %h expected %h", {h, l}, exp);
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] a, b, h, l;
    logic [1:0] o;
    logic [63:0] exp;
    int lat, elat;
    bit own;
    for (int i = 0; i < n; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      exp = ref_model(o, a, b);
      elat = (o[0] && b == 0) ? 2 : 35;
      run_op(o, a, b, 1'b0, h, l, lat, own);
      tests_run++;
      if ({h, l} !== exp) begin
        tests_failed++;
        $display("FAIL random_%0d_result op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, {h, l}, exp);
      end
      tests_run++;
      if (lat !== elat) begin
        tests_failed++; $display("FAIL random_%0d_latency: got %0d expected %0d", i, lat, elat);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_flush();
    test_reset_midop();
    test_random(800);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
